age_matrix_rs: RTL

Generalised out-of-order reservation station that sits between rename/dispatch and one execute unit (ALU, MUL or BR).
- Holds up to DEPTH waiting instructions and wakes their operands from NUM_CDB parallel broadcast ports, matched by ROB-index tag.
- Selects the oldest fully-ready entry each cycle with an age matrix.
- Frees the slot at issue handshake, not at completion, so the execute unit may be pipelined.

---
 rtl/age_matrix_rs_pkg.sv | 30 +++
 rtl/age_matrix_rs_age_select.sv | 26 ++
 rtl/age_matrix_rs.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/age_matrix_rs_pkg.sv
// Shared constants and record types for the age-matrix reservation station.
// The module parameters of age_matrix_rs default to the constants below.
package age_matrix_rs_pkg;

  localparam int RS_DEPTH         = 8;
  localparam int RS_NUM_CDB       = 3;
  localparam int RS_ROB_IDX_WIDTH = 5;
  localparam int RS_DATA_WIDTH    = 32;
  localparam int RS_PAYLOAD_WIDTH = 16;

  // Entry layout at the default widths; the top builds its own copy from its parameters
  typedef struct packed {
    logic                        valid;
    logic [RS_ROB_IDX_WIDTH-1:0] rob_idx;
    logic [RS_PAYLOAD_WIDTH-1:0] payload;
    logic                        src1_ready;
    logic [RS_ROB_IDX_WIDTH-1:0] src1_tag;
    logic [RS_DATA_WIDTH-1:0]    src1_data;
    logic                        src2_ready;
    logic [RS_ROB_IDX_WIDTH-1:0] src2_tag;
    logic [RS_DATA_WIDTH-1:0]    src2_data;
  } rs_entry_t;

  typedef struct packed {
    logic                        valid;
    logic [RS_ROB_IDX_WIDTH-1:0] tag;
    logic [RS_DATA_WIDTH-1:0]    data;
  } cdb_port_t;

endpackage

// File: rtl/age_matrix_rs_age_select.sv
// Oldest-ready picker: grants the candidate that no other candidate is older than.
// older[j][i] = 1 means entry j was dispatched before entry i.
module rs_age_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            cand,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            grant,
  output logic                        any_grant
);

  always_comb begin
    logic blocked;
    blocked = 1'b0;
    grant   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && cand[j] && older[j][i]) blocked = 1'b1;
      end
      grant[i] = cand[i] && !blocked;
    end
    any_grant = |grant;
  end

endmodule

// File: rtl/age_matrix_rs.sv
// Out-of-order reservation station: CDB wakeup by ROB tag, oldest-ready issue
// via an age matrix, slot released at the issue handshake.
module age_matrix_rs
  import age_matrix_rs_pkg::*;
#(
  parameter int DEPTH         = RS_DEPTH,
  parameter int NUM_CDB       = RS_NUM_CDB,
  parameter int ROB_IDX_WIDTH = RS_ROB_IDX_WIDTH,
  parameter int DATA_WIDTH    = RS_DATA_WIDTH,
  parameter int PAYLOAD_WIDTH = RS_PAYLOAD_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  logic [ROB_IDX_WIDTH-1:0]         disp_rob_idx,
  input  logic [PAYLOAD_WIDTH-1:0]         disp_payload,
  input  logic                             disp_src1_ready,
  input  logic                             disp_src2_ready,
  input  logic [ROB_IDX_WIDTH-1:0]         disp_src1_tag,
  input  logic [ROB_IDX_WIDTH-1:0]         disp_src2_tag,
  input  logic [DATA_WIDTH-1:0]            disp_src1_data,
  input  logic [DATA_WIDTH-1:0]            disp_src2_data,
  input  logic [NUM_CDB-1:0]               cdb_valid,
  input  logic [NUM_CDB*ROB_IDX_WIDTH-1:0] cdb_tag,
  input  logic [NUM_CDB*DATA_WIDTH-1:0]    cdb_data,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [ROB_IDX_WIDTH-1:0]         issue_rob_idx,
  output logic [PAYLOAD_WIDTH-1:0]         issue_payload,
  output logic [DATA_WIDTH-1:0]            issue_src1_data,
  output logic [DATA_WIDTH-1:0]            issue_src2_data,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                     valid;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic                     src1_ready;
    logic [ROB_IDX_WIDTH-1:0] src1_tag;
    logic [DATA_WIDTH-1:0]    src1_data;
    logic                     src2_ready;
    logic [ROB_IDX_WIDTH-1:0] src2_tag;
    logic [DATA_WIDTH-1:0]    src2_data;
  } entry_t;

  entry_t                        entries [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0]   older;
  logic [DEPTH-1:0]              valid_vec;
  logic [DEPTH-1:0]              cand;
  logic [DEPTH-1:0]              grant;
  logic                          any_grant;
  logic [IDX_W-1:0]              free_idx;
  logic                          disp_fire;
  logic                          issue_fire;
  entry_t                        new_entry;
  logic [ROB_IDX_WIDTH-1:0]      cdb_tag_a  [NUM_CDB];
  logic [DATA_WIDTH-1:0]         cdb_data_a [NUM_CDB];
  logic [DEPTH-1:0]              wake1;
  logic [DEPTH-1:0]              wake2;
  logic [DATA_WIDTH-1:0]         wake1_data [DEPTH];
  logic [DATA_WIDTH-1:0]         wake2_data [DEPTH];

  for (genvar k = 0; k < NUM_CDB; k++) begin : g_cdb
    assign cdb_tag_a[k]  = cdb_tag[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
    assign cdb_data_a[k] = cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    occupancy = '0;
    free_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries[i].valid;
      cand[i]      = entries[i].valid && entries[i].src1_ready && entries[i].src2_ready;
      occupancy    = occupancy + OCC_W'(entries[i].valid);
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_vec[i]) free_idx = IDX_W'(i);
    end
  end

  assign disp_ready = (occupancy < OCC_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign issue_fire = issue_valid && issue_ready;

  // Descending port scan so the lowest matching CDB port has the final say
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i]      = 1'b0;
      wake2[i]      = 1'b0;
      wake1_data[i] = '0;
      wake2_data[i] = '0;
      for (int k = NUM_CDB-1; k >= 0; k--) begin
        if (cdb_valid[k] && cdb_tag_a[k] == entries[i].src1_tag) begin
          wake1[i]      = 1'b1;
          wake1_data[i] = cdb_data_a[k];
        end
        if (cdb_valid[k] && cdb_tag_a[k] == entries[i].src2_tag) begin
          wake2[i]      = 1'b1;
          wake2_data[i] = cdb_data_a[k];
        end
      end
    end
  end

  always_comb begin
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.rob_idx    = disp_rob_idx;
    new_entry.payload    = disp_payload;
    new_entry.src1_ready = disp_src1_ready;
    new_entry.src1_tag   = disp_src1_tag;
    new_entry.src1_data  = disp_src1_data;
    new_entry.src2_ready = disp_src2_ready;
    new_entry.src2_tag   = disp_src2_tag;
    new_entry.src2_data  = disp_src2_data;
    for (int k = NUM_CDB-1; k >= 0; k--) begin
      if (!disp_src1_ready && cdb_valid[k] && cdb_tag_a[k] == disp_src1_tag) begin
        new_entry.src1_ready = 1'b1;
        new_entry.src1_data  = cdb_data_a[k];
      end
      if (!disp_src2_ready && cdb_valid[k] && cdb_tag_a[k] == disp_src2_tag) begin
        new_entry.src2_ready = 1'b1;
        new_entry.src2_data  = cdb_data_a[k];
      end
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_select (
    .cand      (cand),
    .older     (older),
    .grant     (grant),
    .any_grant (any_grant)
  );

  assign issue_valid = any_grant && !flush;

  always_comb begin
    issue_rob_idx   = '0;
    issue_payload   = '0;
    issue_src1_data = '0;
    issue_src2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        issue_rob_idx   = issue_rob_idx   | entries[i].rob_idx;
        issue_payload   = issue_payload   | entries[i].payload;
        issue_src1_data = issue_src1_data | entries[i].src1_data;
        issue_src2_data = issue_src2_data | entries[i].src2_data;
      end
    end
  end

  // A new entry is younger than every live entry; stale bits of dead entries are rewritten on reuse
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
      older <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_fire && grant[i]) begin
          entries[i].valid <= 1'b0;
        end else if (entries[i].valid) begin
          if (!entries[i].src1_ready && wake1[i]) begin
            entries[i].src1_ready <= 1'b1;
            entries[i].src1_data  <= wake1_data[i];
          end
          if (!entries[i].src2_ready && wake2[i]) begin
            entries[i].src2_ready <= 1'b1;
            entries[i].src2_data  <= wake2_data[i];
          end
        end
      end
      if (disp_fire) begin
        entries[free_idx] <= new_entry;
        for (int j = 0; j < DEPTH; j++) begin
          older[free_idx][j] <= 1'b0;
          older[j][free_idx] <= valid_vec[j];
        end
      end
    end
  end

endmodule
